// File: rtl/cmp_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: FSM states,
// K/L reset value and the gt/lt/eq result vector.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // {K, L}; both set means "equal so far"
    localparam logic [1:0] KL_RESET = 2'b11;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } result_t;

    localparam result_t RES_NONE = '0;

    function automatic result_t kl_to_result(input logic [1:0] kl);
        result_t r;
        r.gt = kl[1] & ~kl[0];
        r.lt = ~kl[1] & kl[0];
        r.eq = kl[1] & kl[0];
        return r;
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One K/L magnitude-comparison cell: folds a single bit pair (A, B) into the
// running comparison state. Greater and less states are absorbing.
module cmp_bit_cell (
    input  logic k_i,
    input  logic l_i,
    input  logic a_i,
    input  logic b_i,
    output logic k_o,
    output logic l_o
);

    always_comb begin
        k_o = ~l_i | (k_i & a_i) | (k_i & ~b_i);
        l_o = ~k_i | (l_i & b_i) | (l_i & ~a_i);
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Sequencer that streams two captured words MSB-first through one K/L cell
// and reports gt/lt/eq with a one-cycle done pulse.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [WIDTH-1:0]             a_in,
    input  logic [WIDTH-1:0]             b_in,
    output logic                         busy,
    output logic                         done,
    output logic                         gt,
    output logic                         lt,
    output logic                         eq,
    output logic [$clog2(WIDTH+1)-1:0]   bits_used
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [1:0]       kl_q, kl_d;
    logic [1:0]       kl_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    result_t          res_q, res_d;
    logic [CW-1:0]    bits_q, bits_d;

    cmp_bit_cell u_cell (
        .k_i (kl_q[1]),
        .l_i (kl_q[0]),
        .a_i (sha_q[WIDTH-1]),
        .b_i (shb_q[WIDTH-1]),
        .k_o (kl_next[1]),
        .l_o (kl_next[0])
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        kl_d    = kl_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bits_d  = bits_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sha_d   = a_in;
                    shb_d   = b_in;
                    kl_d    = KL_RESET;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    kl_d  = kl_next;
                    sha_d = {sha_q[WIDTH-2:0], 1'b0};
                    shb_d = {shb_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    // Results are registered on the edge entering DONE so they
                    // are already valid while done is high.
                    if ((cnt_q == CW'(WIDTH - 1)) ||
                        (EARLY_EXIT && (kl_next[1] != kl_next[0]))) begin
                        state_d = DONE;
                        res_d   = kl_to_result(kl_next);
                        bits_d  = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            kl_q    <= KL_RESET;
            cnt_q   <= '0;
            res_q   <= RES_NONE;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            kl_q    <= kl_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bits_q  <= bits_d;
        end
    end

    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign gt        = res_q.gt;
    assign lt        = res_q.lt;
    assign eq        = res_q.eq;
    assign bits_used = bits_q;

    kl_never_zero: assert property (@(posedge clk) disable iff (!rst_n) kl_q != 2'b00);

endmodule
